memoria_dados_resp: RTL and testbench

Data-memory responder: the target side of the control unit's LerMEM/EscMEM memory interface. Accepts one read or write request per transaction from the datapath, inserts a configurable number of wait states, performs the access on an internal byte array, and returns a one-cycle Pronto strobe, with read data for reads. Sits between the datapath address/data buses (address = Rb + short immediate, produced by the ALU) and storage; the PC stall logic uses Ocupado/Pronto.

---
 rtl/pacote_mem.sv | 19 +
 rtl/banco_memoria.sv | 32 +++
 rtl/memoria_dados_resp.sv | 149 ++++++++++++++
 tb/tb_memoria_dados_resp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_mem.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, default bus widths and the request-type
// constants used by memoria_dados_resp and banco_memoria.
package pacote_mem;

  localparam int LARG_DADO = 8;  // data bus width
  localparam int LARG_END  = 8;  // address bus width

  // Request type stored with a captured transaction
  localparam logic LEITURA = 1'b0;
  localparam logic ESCRITA = 1'b1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    ESPERA   = 2'b01,
    RESPONDE = 2'b10
  } estado_t;

endpackage

// File: rtl/banco_memoria.sv
// DEPTH x 8 storage array for the data-memory responder.
// Ports:
//   clock  - rising-edge clock
//   we     - write enable: mem[addr] <= din at the edge
//   re     - read enable:  dout <= mem[addr] at the edge
//   addr   - word address (already reduced to the array range)
//   din    - write data
//   dout   - registered read data, holds between reads
// Contents have no reset; they start at zero and survive a reset of the
// surrounding logic.
module banco_memoria
  import pacote_mem::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [LARG_DADO-1:0] din,
  output logic [LARG_DADO-1:0] dout
);

  logic [LARG_DADO-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/memoria_dados_resp.sv
// Data-memory responder: target side of the LerMEM/EscMEM interface.
// Captures one read or write request while idle, waits LATENCIA cycles,
// performs the access on banco_memoria and raises Pronto for one cycle.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   LerMEM/EscMEM - read / write request strobes (sampled only when idle)
//   Endereco      - byte address, aliased modulo DEPTH
//   DadoEscrita   - write data, captured with the request
//   DadoLido      - read data, held until the next read completes
//   Pronto        - one-cycle completion strobe
//   Ocupado       - high whenever a transaction is in progress
//   Erro          - one-cycle strobe after both strobes were seen together
module memoria_dados_resp
  import pacote_mem::*;
#(
  parameter int DEPTH    = 256,
  parameter int LATENCIA = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 LerMEM,
  input  logic                 EscMEM,
  input  logic [LARG_END-1:0]  Endereco,
  input  logic [LARG_DADO-1:0] DadoEscrita,
  output logic [LARG_DADO-1:0] DadoLido,
  output logic                 Pronto,
  output logic                 Ocupado,
  output logic                 Erro
);

  localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT = 4'(LATENCIA);

  estado_t              estado;
  logic [3:0]           contador;
  logic [AW-1:0]        end_cap;
  logic [LARG_DADO-1:0] dado_cap;
  logic                 tipo_cap;
  logic                 pronto_reg;
  logic                 ocupado_reg;
  logic                 erro_reg;
  logic                 lido_valido;
  logic [LARG_DADO-1:0] banco_dout;

  logic                 pedido_unico;
  logic                 pedido_duplo;
  logic [AW-1:0]        end_in;
  logic                 tipo_in;

  assign pedido_unico = LerMEM ^ EscMEM;
  assign pedido_duplo = LerMEM & EscMEM;
  // Masking with DEPTH-1 gives the modulo alias for power-of-two depths
  assign end_in  = AW'(Endereco & LARG_END'(DEPTH - 1));
  assign tipo_in = EscMEM ? ESCRITA : LEITURA;

  // The array is touched on the edge that enters RESPONDE. With zero
  // latency that is the capture edge itself, so the live request feeds the
  // array directly; otherwise the captured copy is used on the last wait edge.
  logic                 acesso_direto;
  logic                 acesso_espera;
  logic                 acesso;
  logic                 tipo_acc;
  logic [AW-1:0]        end_acc;
  logic [LARG_DADO-1:0] dado_acc;
  logic                 banco_we;
  logic                 banco_re;

  assign acesso_direto = (estado == OCIOSO) && pedido_unico && (LAT == 4'd0);
  assign acesso_espera = (estado == ESPERA) && (contador == 4'd1);
  // The array has no reset, so keep it untouched while reset is asserted
  assign acesso   = (acesso_direto || acesso_espera) && !reset;
  assign tipo_acc = acesso_direto ? tipo_in     : tipo_cap;
  assign end_acc  = acesso_direto ? end_in      : end_cap;
  assign dado_acc = acesso_direto ? DadoEscrita : dado_cap;
  assign banco_we = acesso && (tipo_acc == ESCRITA);
  assign banco_re = acesso && (tipo_acc == LEITURA);

  banco_memoria #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_banco (
    .clock (clock),
    .we    (banco_we),
    .re    (banco_re),
    .addr  (end_acc),
    .din   (dado_acc),
    .dout  (banco_dout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      contador    <= '0;
      end_cap     <= '0;
      dado_cap    <= '0;
      tipo_cap    <= LEITURA;
      pronto_reg  <= 1'b0;
      ocupado_reg <= 1'b0;
      erro_reg    <= 1'b0;
      lido_valido <= 1'b0;
    end else begin
      pronto_reg <= 1'b0;
      erro_reg   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (pedido_unico) begin
            end_cap     <= end_in;
            dado_cap    <= DadoEscrita;
            tipo_cap    <= tipo_in;
            contador    <= LAT;
            ocupado_reg <= 1'b1;
            if (LAT == 4'd0) begin
              estado     <= RESPONDE;
              pronto_reg <= 1'b1;
            end else begin
              estado <= ESPERA;
            end
          end else if (pedido_duplo) begin
            erro_reg <= 1'b1;
          end
        end
        ESPERA: begin
          contador <= contador - 4'd1;
          if (contador == 4'd1) begin
            estado     <= RESPONDE;
            pronto_reg <= 1'b1;
          end
        end
        RESPONDE: begin
          estado      <= OCIOSO;
          ocupado_reg <= 1'b0;
        end
        default: begin
          estado      <= OCIOSO;
          ocupado_reg <= 1'b0;
        end
      endcase
      // Once any read has completed, the bank's output register is the
      // authoritative DadoLido; before that (and after reset) it reads zero.
      if (banco_re) lido_valido <= 1'b1;
    end
  end

  assign DadoLido = lido_valido ? banco_dout : '0;
  assign Pronto   = pronto_reg;
  assign Ocupado  = ocupado_reg;
  assign Erro     = erro_reg;

endmodule

// File: tb/tb_memoria_dados_resp.sv
module tb_memoria_dados_resp;

  // Three responders: 0 = DEPTH 256 / LATENCIA 2, 1 = LATENCIA 0, 2 = DEPTH 16
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ler  [3];
  logic       esc  [3];
  logic [7:0] ender[3];
  logic [7:0] din  [3];
  logic [7:0] lido [3];
  logic       pronto[3];
  logic       ocup [3];
  logic       erro [3];

  int         lat_de  [3] = '{2, 0, 2};
  logic [7:0] mask_de [3] = '{8'hFF, 8'hFF, 8'h0F};
  logic [7:0] modelo  [3][256];

  typedef struct {
    int         d;
    logic       escrita;
    logic [7:0] addr;
    logic [7:0] dado;
  } item_t;
  item_t sb[$];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  memoria_dados_resp #(.DEPTH(256), .LATENCIA(2)) u_a (
    .clock(clock), .reset(reset), .LerMEM(ler[0]), .EscMEM(esc[0]),
    .Endereco(ender[0]), .DadoEscrita(din[0]), .DadoLido(lido[0]),
    .Pronto(pronto[0]), .Ocupado(ocup[0]), .Erro(erro[0]));

  memoria_dados_resp #(.DEPTH(256), .LATENCIA(0)) u_z (
    .clock(clock), .reset(reset), .LerMEM(ler[1]), .EscMEM(esc[1]),
    .Endereco(ender[1]), .DadoEscrita(din[1]), .DadoLido(lido[1]),
    .Pronto(pronto[1]), .Ocupado(ocup[1]), .Erro(erro[1]));

  memoria_dados_resp #(.DEPTH(16), .LATENCIA(2)) u_w (
    .clock(clock), .reset(reset), .LerMEM(ler[2]), .EscMEM(esc[2]),
    .Endereco(ender[2]), .DadoEscrita(din[2]), .DadoLido(lido[2]),
    .Pronto(pronto[2]), .Ocupado(ocup[2]), .Erro(erro[2]));

  // One complete transaction with the strobe dropped as soon as Pronto is seen.
  task automatic transacao(input int d, input logic escrita, input logic [7:0] a, input logic [7:0] w);
    item_t it;
    item_t ex;
    bit    visto;
    logic [7:0] lido_ant;
    it.d       = d;
    it.escrita = escrita;
    it.addr    = a & mask_de[d];
    it.dado    = escrita ? w : modelo[d][a & mask_de[d]];
    sb.push_back(it);
    ex    = it;
    visto = 0;
    ender[d] = a;
    din[d]   = w;
    if (escrita) esc[d] = 1'b1; else ler[d] = 1'b1;
    for (int k = 1; k <= 20 && !visto; k++) begin
      @(negedge clock);
      if (pronto[d] === 1'b1) begin
        visto = 1;
        ex = sb.pop_front();
        total++;
        if (k != lat_de[ex.d] + 1) begin
          bad++;
          $display("FAIL latency dut=%0d: pronto at cycle %0d, required %0d", d, k, lat_de[ex.d] + 1);
        end
        if (!ex.escrita) begin
          total++;
          if (lido[d] !== ex.dado) begin
            bad++;
            $display("FAIL read_data dut=%0d addr=%h: got %h, required %h", d, ex.addr, lido[d], ex.dado);
          end
        end else begin
          modelo[d][ex.addr] = ex.dado;
        end
        ler[d] = 1'b0;
        esc[d] = 1'b0;
      end
      total++;
      if (ocup[d] !== 1'b1) begin
        bad++;
        $display("FAIL busy dut=%0d cycle %0d: got %b, required 1", d, k, ocup[d]);
      end
    end
    if (!visto) begin
      total++;
      bad++;
      $display("FAIL timeout dut=%0d: no pronto within 20 cycles", d);
      void'(sb.pop_front());
      ler[d] = 1'b0;
      esc[d] = 1'b0;
    end
    lido_ant = lido[d];
    @(negedge clock);
    total++;
    if (ocup[d] !== 1'b0 || pronto[d] !== 1'b0) begin
      bad++;
      $display("FAIL after_done dut=%0d: busy=%b pronto=%b, required 0 0", d, ocup[d], pronto[d]);
    end
    if (!escrita) begin
      total++;
      if (lido[d] !== lido_ant) begin
        bad++;
        $display("FAIL read_hold dut=%0d: got %h, required %h", d, lido[d], lido_ant);
      end
    end
    $display("txn dut=%0d %s addr=%h data=%h", d, escrita ? "write" : "read", it.addr, it.dado);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (lido[d] !== 8'h00 || pronto[d] !== 1'b0 || ocup[d] !== 1'b0 || erro[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut=%0d: lido=%h pronto=%b busy=%b erro=%b, required 00 0 0 0",
                 d, lido[d], pronto[d], ocup[d], erro[d]);
      end
    end
    $display("txn reset checked");
  endtask

  task automatic test_escrita_leitura();
    transacao(0, 1'b1, 8'h05, 8'hA7);
    transacao(0, 1'b0, 8'h05, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] esp;
    esp = modelo[0][8'h05];
    ender[0] = 8'h05;
    ler[0]   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      total++;
      if (pronto[0] !== ((k == 3) || (k == 7))) begin
        bad++;
        $display("FAIL b2b_pronto cycle %0d: got %b, required %b", k, pronto[0], (k == 3) || (k == 7));
      end
      total++;
      if (ocup[0] !== !((k == 4) || (k == 8))) begin
        bad++;
        $display("FAIL b2b_busy cycle %0d: got %b, required %b", k, ocup[0], !((k == 4) || (k == 8)));
      end
      if (k == 3 || k == 7) begin
        total++;
        if (lido[0] !== esp) begin
          bad++;
          $display("FAIL b2b_data cycle %0d: got %h, required %h", k, lido[0], esp);
        end
        $display("txn dut=0 read addr=05 data=%h (held strobe)", esp);
      end
      if (k == 7) ler[0] = 1'b0;
    end
  endtask

  task automatic test_erro();
    ender[0] = 8'h05;
    din[0]   = 8'h00;
    ler[0]   = 1'b1;
    esc[0]   = 1'b1;
    @(negedge clock);
    ler[0] = 1'b0;
    esc[0] = 1'b0;
    total++;
    if (erro[0] !== 1'b1 || ocup[0] !== 1'b0 || pronto[0] !== 1'b0) begin
      bad++;
      $display("FAIL both_strobes: erro=%b busy=%b pronto=%b, required 1 0 0", erro[0], ocup[0], pronto[0]);
    end
    @(negedge clock);
    total++;
    if (erro[0] !== 1'b0 || ocup[0] !== 1'b0 || pronto[0] !== 1'b0) begin
      bad++;
      $display("FAIL erro_pulse: erro=%b busy=%b pronto=%b, required 0 0 0", erro[0], ocup[0], pronto[0]);
    end
    $display("txn dut=0 both strobes addr=05");
    transacao(0, 1'b0, 8'h05, 8'h00);
  endtask

  task automatic test_ignora();
    logic [7:0] esp1;
    logic [7:0] esp2;
    esp1 = modelo[0][8'h05];
    esp2 = modelo[0][8'h07];
    ender[0] = 8'h05;
    ler[0]   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      total++;
      if (pronto[0] !== ((k == 3) || (k == 7))) begin
        bad++;
        $display("FAIL ignore_pronto cycle %0d: got %b, required %b", k, pronto[0], (k == 3) || (k == 7));
      end
      if (k == 3 || k == 7) begin
        total++;
        if (lido[0] !== (k == 3 ? esp1 : esp2)) begin
          bad++;
          $display("FAIL ignore_data cycle %0d: got %h, required %h", k, lido[0], k == 3 ? esp1 : esp2);
        end
        $display("txn dut=0 read addr=%s data=%h", k == 3 ? "05" : "07", k == 3 ? esp1 : esp2);
      end
      if (k == 1) ler[0] = 1'b0;
      if (k == 2) begin
        ler[0]   = 1'b1;
        ender[0] = 8'h07;
      end
      if (k == 7) ler[0] = 1'b0;
    end
  endtask

  task automatic test_reset_meio();
    transacao(0, 1'b0, 8'h05, 8'h00);
    ender[0] = 8'h07;
    din[0]   = 8'hFF;
    esc[0]   = 1'b1;
    @(negedge clock);
    reset  = 1'b1;
    esc[0] = 1'b0;
    #1;
    total++;
    if (lido[0] !== 8'h00 || pronto[0] !== 1'b0 || ocup[0] !== 1'b0 || erro[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: lido=%h pronto=%b busy=%b erro=%b, required 00 0 0 0",
               lido[0], pronto[0], ocup[0], erro[0]);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      total++;
      if (pronto[0] !== 1'b0 || ocup[0] !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_quiet cycle %0d: pronto=%b busy=%b, required 0 0", k, pronto[0], ocup[0]);
      end
    end
    $display("txn dut=0 write addr=07 data=ff discarded by reset");
    transacao(0, 1'b0, 8'h07, 8'h00);
  endtask

  task automatic test_latencia_zero();
    transacao(1, 1'b1, 8'h10, 8'h3C);
    transacao(1, 1'b0, 8'h10, 8'h00);
  endtask

  task automatic test_wrap();
    transacao(2, 1'b1, 8'h23, 8'h11);
    transacao(2, 1'b0, 8'h03, 8'h00);
    total++;
    if (lido[2] !== 8'h11) begin
      bad++;
      $display("FAIL wrap: got %h, required 11", lido[2]);
    end
    transacao(2, 1'b1, 8'hF9, 8'h5A);
    transacao(2, 1'b0, 8'h09, 8'h00);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      ler[d]   = 1'b0;
      esc[d]   = 1'b0;
      ender[d] = 8'h00;
      din[d]   = 8'h00;
      for (int i = 0; i < 256; i++) modelo[d][i] = 8'h00;
    end
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_escrita_leitura();
    test_back_to_back();
    test_erro();
    test_ignora();
    test_reset_meio();
    test_latencia_zero();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
